// File: rtl/enc_pkg.sv
// Shared types, widths and helper functions for the request encoder.
package enc_pkg;

    localparam int REQ_W  = 16;
    localparam int IDX_W  = 4;
    localparam int PEND_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Number of set bits in a request vector (0..16).
    function automatic logic [PEND_W-1:0] popcount16(input logic [REQ_W-1:0] v);
        logic [PEND_W-1:0] c;
        c = '0;
        for (int i = 0; i < REQ_W; i++) begin
            c = c + PEND_W'(v[i]);
        end
        return c;
    endfunction

    // Single-bit mask selecting index i.
    function automatic logic [REQ_W-1:0] idx_onehot(input logic [IDX_W-1:0] i);
        logic [REQ_W-1:0] m;
        m    = '0;
        m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/request_encoder16_if.sv
// Bus bundle between a request producer/consumer and request_encoder16.
//
// Handshake rules:
//   - A vector is taken on a rising edge where ready=1, En=1 and load=1.
//   - An index is consumed on a rising edge where valid=1 and ack=1; X and
//     valid do not change until then (unless En drops, which aborts).
//   - ack with valid=0 and load with ready=0 have no effect.
interface request_encoder16_if;
    import enc_pkg::*;

    logic                En;
    logic                load;
    logic [REQ_W-1:0]    D;
    logic                ack;
    logic [IDX_W-1:0]    X;
    logic                valid;
    logic                ready;
    logic                zero;
    logic [PEND_W-1:0]   pending;
    state_t              state_dbg;

    modport master (
        output En, load, D, ack,
        input  X, valid, ready, zero, pending, state_dbg
    );

    modport slave (
        input  En, load, D, ack,
        output X, valid, ready, zero, pending, state_dbg
    );

endinterface

// File: rtl/prio_enc16.sv
// Combinational 16->4 priority finder; MSB_FIRST picks the highest set bit.
module prio_enc16
    import enc_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic [REQ_W-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan so that the preferred end of the vector is visited last and wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < REQ_W; i++) begin
            if (MSB_FIRST != 0) begin
                if (req_i[i]) idx_o = IDX_W'(i);
            end else begin
                if (req_i[REQ_W-1-i]) idx_o = IDX_W'(REQ_W-1-i);
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/request_encoder16.sv
// Captures a 16-bit request vector and presents the set indices one at a
// time, in priority order, on a valid/ack handshake.
module request_encoder16
    import enc_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    request_encoder16_if.slave   bus
);

    state_t           state_q, state_d;
    logic [REQ_W-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] x_q, x_d;
    logic             zero_q, zero_d;

    logic             capture;
    logic [REQ_W-1:0] pend_cleared;
    logic [REQ_W-1:0] enc_in;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    assign capture      = (state_q == IDLE) && bus.En && bus.load;
    assign pend_cleared = pend_q & ~idx_onehot(x_q);

    // The finder looks at the incoming vector while idle and at the
    // post-ack remainder while emitting, so the next index is ready one
    // cycle after each capture or ack.
    always_comb begin
        enc_in = (state_q == IDLE) ? bus.D : pend_cleared;
    end

    prio_enc16 #(
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .req_i (enc_in),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping En while emitting aborts immediately.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (capture && enc_any) state_d = EMIT;
            end
            EMIT: begin
                if (!bus.En) begin
                    state_d = IDLE;
                end else if (bus.ack && !enc_any) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: pending mask, presented index, zero pulse.
    always_comb begin
        pend_d = pend_q;
        x_d    = x_q;
        zero_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    if (enc_any) begin
                        pend_d = bus.D;
                        x_d    = enc_idx;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (!bus.En) begin
                    pend_d = '0;
                    x_d    = '0;
                end else if (bus.ack) begin
                    pend_d = pend_cleared;
                    x_d    = enc_any ? enc_idx : '0;
                end
            end
            default: begin
                pend_d = '0;
                x_d    = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            x_q    <= '0;
            zero_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            x_q    <= x_d;
            zero_q <= zero_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.valid     = (state_q == EMIT);
        bus.ready     = (state_q == IDLE);
        bus.X         = x_q;
        bus.zero      = zero_q;
        bus.pending   = popcount16(pend_q);
        bus.state_dbg = state_q;
    end

endmodule

// File: tb/tb_request_encoder16.sv
module tb_request_encoder16;
    import enc_pkg::*;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    typedef struct {
        logic        en;
        logic        load;
        logic [15:0] d;
        logic        ack;
        logic        valid;
        logic        ready;
        logic        zero;
        logic [4:0]  pend;
        logic [3:0]  x0;
        logic [3:0]  x1;
    } vec_t;

    logic clk;
    logic rst;
    logic        en;
    logic        load;
    logic [15:0] d;
    logic        ack;

    int n_checks;
    int n_fail;

    vec_t vecs[20];

    request_encoder16_if if0 ();
    request_encoder16_if if1 ();

    assign if0.En   = en;
    assign if0.load = load;
    assign if0.D    = d;
    assign if0.ack  = ack;
    assign if1.En   = en;
    assign if1.load = load;
    assign if1.D    = d;
    assign if1.ack  = ack;

    request_encoder16 #(.MSB_FIRST(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    request_encoder16 #(.MSB_FIRST(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Both instances share stimulus and timing; only X differs in order.
    task automatic check_all(input string tag, input logic v, input logic r, input logic z,
                             input logic [4:0] p, input logic [3:0] x0, input logic [3:0] x1);
        chk({tag, ".valid"},    16'(if0.valid),   16'(v));
        chk({tag, ".ready"},    16'(if0.ready),   16'(r));
        chk({tag, ".zero"},     16'(if0.zero),    16'(z));
        chk({tag, ".pending"},  16'(if0.pending), 16'(p));
        chk({tag, ".X_lsb"},    16'(if0.X),       16'(x0));
        chk({tag, ".valid_m"},  16'(if1.valid),   16'(v));
        chk({tag, ".pending_m"},16'(if1.pending), 16'(p));
        chk({tag, ".X_msb"},    16'(if1.X),       16'(x1));
    endtask

    // driver: apply inputs, clock once, sample 1 time unit after the edge
    task automatic step(input logic e, input logic l, input logic [15:0] dv, input logic a);
        en   = e;
        load = l;
        d    = dv;
        ack  = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        d    = '0;
        ack  = 1'b0;

        //           en load d        ack  valid ready zero pend  x0     x1
        vecs[0]  = '{H, H, 16'h8421, H,   H, L, L, 5'd4, 4'd0,  4'd15};
        vecs[1]  = '{H, L, 16'h0000, H,   H, L, L, 5'd3, 4'd5,  4'd10};
        vecs[2]  = '{H, L, 16'h0000, H,   H, L, L, 5'd2, 4'd10, 4'd5};
        vecs[3]  = '{H, L, 16'h0000, H,   H, L, L, 5'd1, 4'd15, 4'd0};
        vecs[4]  = '{H, L, 16'h0000, H,   L, H, L, 5'd0, 4'd0,  4'd0};
        vecs[5]  = '{H, L, 16'h0000, L,   L, H, L, 5'd0, 4'd0,  4'd0};
        vecs[6]  = '{H, H, 16'h0000, L,   L, H, H, 5'd0, 4'd0,  4'd0};
        vecs[7]  = '{H, L, 16'h0000, L,   L, H, L, 5'd0, 4'd0,  4'd0};
        vecs[8]  = '{H, H, 16'h00F0, L,   H, L, L, 5'd4, 4'd4,  4'd7};
        vecs[9]  = '{H, L, 16'h0000, H,   H, L, L, 5'd3, 4'd5,  4'd6};
        vecs[10] = '{L, L, 16'h0000, H,   L, H, L, 5'd0, 4'd0,  4'd0};
        vecs[11] = '{H, H, 16'h0003, L,   H, L, L, 5'd2, 4'd0,  4'd1};
        vecs[12] = '{H, H, 16'h0100, H,   H, L, L, 5'd1, 4'd1,  4'd0};
        vecs[13] = '{H, H, 16'h0100, H,   L, H, L, 5'd0, 4'd0,  4'd0};
        vecs[14] = '{H, L, 16'h0000, L,   L, H, L, 5'd0, 4'd0,  4'd0};
        vecs[15] = '{L, H, 16'h0100, L,   L, H, L, 5'd0, 4'd0,  4'd0};
        vecs[16] = '{L, H, 16'h0000, L,   L, H, L, 5'd0, 4'd0,  4'd0};
        vecs[17] = '{H, H, 16'h0100, L,   H, L, L, 5'd1, 4'd8,  4'd8};
        vecs[18] = '{H, L, 16'h0000, H,   L, H, L, 5'd0, 4'd0,  4'd0};
        vecs[19] = '{H, L, 16'h0000, H,   L, H, L, 5'd0, 4'd0,  4'd0};

        // reset takes effect without any clock edge
        #2;
        check_all("reset_async", L, H, L, 5'd0, 4'd0, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset_held", L, H, L, 5'd0, 4'd0, 4'd0);
        rst = 1'b0;

        // table-driven vectors
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].en, vecs[i].load, vecs[i].d, vecs[i].ack);
            check_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].ready, vecs[i].zero,
                      vecs[i].pend, vecs[i].x0, vecs[i].x1);
        end

        // all sixteen requests, ack toggled every other cycle
        step(H, H, 16'hFFFF, L);
        check_all("full_load", H, L, L, 5'd16, 4'd0, 4'd15);
        for (int k = 0; k < 16; k++) begin
            step(H, L, 16'h0000, L);
            check_all($sformatf("full_hold%0d", k), H, L, L, 5'(16 - k), 4'(k), 4'(15 - k));
            step(H, L, 16'h0000, H);
            if (k < 15) begin
                check_all($sformatf("full_ack%0d", k), H, L, L, 5'(15 - k), 4'(k + 1), 4'(14 - k));
            end else begin
                check_all("full_done", L, H, L, 5'd0, 4'd0, 4'd0);
            end
        end

        // asynchronous reset in the middle of emitting
        step(H, H, 16'h0003, L);
        check_all("rst_mid_load", H, L, L, 5'd2, 4'd0, 4'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all("rst_mid_async", L, H, L, 5'd0, 4'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(H, L, 16'h0000, H);
            check_all($sformatf("rst_mid_after%0d", k), L, H, L, 5'd0, 4'd0, 4'd0);
        end

        // fresh load still works after the reset
        step(H, H, 16'h0003, L);
        check_all("post_rst_load", H, L, L, 5'd2, 4'd0, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/request_encoder16.md
REQUEST_ENCODER16 -- requirements
Module: request_encoder16

Interface
REQ-001 Parameter: MSB_FIRST, 0, service order (0 = lowest set index first, 1 = highest first).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 En  input  1  block enable; gates load and aborts service when low.
REQ-005 load  input  1  one-cycle strobe capturing D when ready=1 and En=1.
REQ-006 D  input  16  request vector; bit i = request for index i.
REQ-007 ack  input  1  consumer accepts current X when valid=1.
REQ-008 X  output  4  encoded index of the currently presented request.
REQ-009 valid  output  1  X holds a pending request.
REQ-010 ready  output  1  block idle, able to capture a new vector.
REQ-011 zero  output  1  one-cycle pulse: load accepted with D==16'h0000.
REQ-012 pending  output  5  count of requests not yet acknowledged, 0..16.

Function
REQ-013 The block SHALL implement states IDLE and EMIT; ready=1 exactly in IDLE, valid=1 exactly in EMIT.
REQ-014 IDLE + load=1 + En=1 + D!=0 SHALL register D into a 16-bit pend register and enter EMIT next cycle.
REQ-015 IDLE + load=1 + En=1 + D==0 SHALL remain IDLE and pulse zero for exactly one cycle.
REQ-016 load SHALL be ignored when En=0 or in EMIT; no state, pend or zero change.
REQ-017 In EMIT, X SHALL equal the lowest (MSB_FIRST=0) or highest (MSB_FIRST=1) set bit index of pend, registered, valid the cycle after capture (latency 1).
REQ-018 X and valid SHALL remain stable until ack=1 is sampled while valid=1.
REQ-019 On ack in EMIT, that bit SHALL clear from pend; if any bits remain, valid stays 1 and X shows the next index the following cycle (one index per cycle sustained).
REQ-020 On ack of the last remaining bit, the block SHALL return to IDLE next cycle with valid=0, ready=1, X=0.
REQ-021 ack while valid=0 SHALL be ignored.
REQ-022 pending SHALL equal popcount(pend), 16 after capturing 16'hFFFF, decrementing by 1 per accepted ack; 0 in IDLE.
REQ-023 En=0 in EMIT SHALL abort: next cycle IDLE, pend cleared, valid=0, pending=0; a same-cycle ack is discarded.
REQ-024 load and ack in the same cycle as the final ack SHALL NOT capture the new vector (ready=0 that cycle).

Reset
REQ-025 rst=1 SHALL immediately force IDLE, pend=0, X=0, valid=0, zero=0, pending=0, ready=1, independent of clk.
REQ-026 Reset mid-EMIT SHALL discard all outstanding requests; after release no stale index is presented.

Structure
REQ-027 Package enc_pkg SHALL hold the state enum (IDLE, EMIT), REQ_W=16 and IDX_W=4 constants.
REQ-028 Sub-module prio_enc16 (combinational 16->4 priority finder with MSB_FIRST parameter and any-set flag) SHALL be instantiated once for next-index selection.
REQ-029 No other sub-modules; all state in request_encoder16.

Verification
REQ-030 Reset then load D=16'h8421, ack held high, MSB_FIRST=0 -> X sequence 0,5,10,15 on four consecutive cycles, then ready=1, pending 4,3,2,1,0.
REQ-031 load D=16'h0000 in IDLE -> zero pulses 1 cycle, ready stays 1, valid stays 0.
REQ-032 load D=16'hFFFF, MSB_FIRST=1, ack toggled every other cycle -> X 15 down to 0, each held until acked, pending starts 16.
REQ-033 load D=16'h00F0, after first ack drop En -> next cycle IDLE, pending=0, valid=0; new load with En=1 accepted.
REQ-034 load D=16'h0003, assert rst asynchronously mid-EMIT -> outputs at reset values before next clk edge; no X=1 after release.
REQ-035 load asserted in EMIT and in the final-ack cycle with D=16'h0100 -> ignored; X never shows 8 until re-loaded in IDLE.
